// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width; never below one bit so WIDTH=2 still gets a counter.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_str.sv
// Gate-level full subtractor: d = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
module fs_str (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    wire axb;
    wire na;
    wire naxb;
    wire t_ab;
    wire t_bin;

    xor g_x0 (axb, a, b);
    xor g_x1 (d, axb, bin);
    not g_n0 (na, a);
    not g_n1 (naxb, axb);
    and g_a0 (t_ab, na, b);
    and g_a1 (t_bin, naxb, bin);
    or  g_o0 (bout, t_ab, t_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b), one bit per clock, LSB first.
// Define SERIAL_SUB_SAT_EN to clamp diff to 0 whenever the final borrow is set.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             out_valid,
    input  logic             out_ready,
    output state_t           dbg_state_o
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             fs_d;
    logic             fs_bout;

    fs_str u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bin_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {fs_d, res_q[WIDTH-1:1]};
                bin_d = fs_bout;
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef SERIAL_SUB_SAT_EN
                    if (fs_bout) begin
                        res_d = '0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Result registers are frozen here; only the handshake moves on.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            bin_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign diff        = res_q;
    assign borrow      = bin_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); honours SERIAL_SUB_SAT_EN.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         out_valid;
    logic         out_ready;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .diff        (diff),
        .borrow      (borrow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected diff for the build under test.
    function automatic logic [W-1:0] exp_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        r = x - y;
`ifdef SERIAL_SUB_SAT_EN
        if (x < y) r = '0;
`endif
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Waits (on negedges) for out_valid; returns number of posedges counted
    // from the accept edge inclusive.
    task automatic wait_out_valid(input int start_edges, output int edges, output logic seen);
        edges = start_edges;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
    endtask

    // One operation with out_ready low until the result is checked.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb, input int exp_lat);
        int   edges;
        logic seen;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, in_ready, 1'b1);
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        check_eq({tag, "_run_in_ready"}, in_ready, 1'b0);
        wait_out_valid(1, edges, seen);
        check_eq({tag, "_ov_seen"}, seen, 1'b1);
        if (exp_lat > 0) check_eq({tag, "_latency"}, edges, exp_lat);
        check_eq({tag, "_diff"}, diff, ed);
        check_eq({tag, "_borrow"}, borrow, eb);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_ov_drop"}, out_valid, 1'b0);
        check_eq({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   edges;
        int   last_acc;
        logic seen;
        logic [W-1:0] ed;
        logic         eb;

        rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_diff", diff, 8'h00);
        check_eq("rst_borrow", borrow, 1'b0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1'b1);

        // Latency is counted with the accept edge as edge 1.
        run_op("v35m12", 8'h35, 8'h12, 8'h23, 1'b0, W + 1);
`ifdef SERIAL_SUB_SAT_EN
        run_op("v10m20", 8'h10, 8'h20, 8'h00, 1'b1, 0);
`else
        run_op("v10m20", 8'h10, 8'h20, 8'hF0, 1'b1, 0);
`endif
        run_op("vFFm01", 8'hFF, 8'h01, 8'hFE, 1'b0, 0);
        run_op("v00m00", 8'h00, 8'h00, 8'h00, 1'b0, 0);
`ifdef SERIAL_SUB_SAT_EN
        run_op("v00mFF", 8'h00, 8'hFF, 8'h00, 1'b1, 0);
`else
        run_op("v00mFF", 8'h00, 8'hFF, 8'h01, 1'b1, 0);
`endif

        // Hold in DONE for 5 cycles with stray in_valid pulses.
        @(negedge clk);
        a = 8'h80; b = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid(1, edges, seen);
        check_eq("hold_ov_seen", seen, 1'b1);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            a = 8'h11; b = 8'h99;
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_out_valid", out_valid, 1'b1);
            check_eq("hold_diff", diff, 8'h7F);
            check_eq("hold_borrow", borrow, 1'b0);
            check_eq("hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("hold_release", out_valid, 1'b0);

        // Reset asserted during the 4th bit-cycle aborts the operation.
        a = 8'h55; b = 8'h0F; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_state", 32'(dbg_state), 32'(IDLE));
        check_eq("abort_out_valid", out_valid, 1'b0);
        check_eq("abort_diff", diff, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("abort_no_ov", seen, 1'b0);
        run_op("v07m03", 8'h07, 8'h03, 8'h04, 1'b0, 0);

        // Back-to-back with in_valid and out_ready tied high, random operands.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] x, y;
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                if (in_ready) seen = 1'b1;
                else @(negedge clk);
            end
            check_eq("b2b_in_ready_seen", seen, 1'b1);
            x = W'($urandom_range(0, 255));
            y = W'($urandom_range(0, 255));
            a = x; b = y;
            exp_q.push_back(exp_diff(x, y));
            eb = (x < y);
            @(posedge clk);
            @(negedge clk);
            if (i > 0) check_eq("b2b_spacing", cyc - last_acc, W + 2);
            last_acc = cyc;
            a = ~x; b = ~y;
            wait_out_valid(1, edges, seen);
            check_eq("b2b_ov_seen", seen, 1'b1);
            ed = exp_q.pop_front();
            check_eq("b2b_diff", diff, ed);
            check_eq("b2b_borrow", borrow, eb);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port a, input, WIDTH bits: minuend.
REQ-005 The block SHALL have port b, input, WIDTH bits: subtrahend.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a and b are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: high only in IDLE; an operand pair is accepted on any edge where in_valid and in_ready are both high.
REQ-008 The block SHALL have port diff, output, WIDTH bits: result (a - b) mod 2^WIDTH.
REQ-009 The block SHALL have port borrow, output, 1 bit: high when a < b (unsigned).
REQ-010 The block SHALL have port out_valid, output, 1 bit: diff and borrow are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE -> RUN on accept: capture a and b into shift registers, clear the borrow flop and load bit counter = 0.
REQ-014 In each RUN cycle, exactly one bit pair (LSB first) SHALL pass through a full subtractor: d = ai^bi^bin, bout = (~ai&bi)|(~(ai^bi)&bin).
REQ-015 d SHALL be shifted into the MSB end of the result register, and bout registered as the next bin.
REQ-016 RUN -> DONE after exactly WIDTH bit-cycles, counter reaching WIDTH-1; out_valid SHALL rise WIDTH+1 edges after the accept edge.
REQ-017 In DONE: out_valid=1; diff and borrow SHALL hold stable until out_valid && out_ready.
REQ-018 DONE -> IDLE on the edge where out_ready=1.
REQ-019 in_ready SHALL be low in RUN and DONE; in_valid SHALL be ignored there, and a and b may change freely there.
REQ-020 out_ready held high before DONE SHALL have no effect; completion takes exactly one DONE cycle.
REQ-021 A new accept SHALL be possible on the edge after DONE -> IDLE (throughput one result per WIDTH+2 cycles).
REQ-022 Outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-023 While rst_n=0 at an edge: state=IDLE, counter=0, borrow flop=0, diff=0, borrow=0, out_valid=0; in_ready=1 from the first edge with rst_n=1.
REQ-024 Reset during RUN or DONE SHALL abort the operation and discard the result; no out_valid pulse SHALL follow.

Configuration
REQ-025 Macro SERIAL_SUB_SAT_EN SHALL, when defined, make the block saturate: if the final borrow=1, diff SHALL read 0 in DONE, with borrow still reported as 1.
REQ-026 Without SERIAL_SUB_SAT_EN, diff SHALL be the raw modulo result; borrow behaviour SHALL be identical in both builds.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/RUN/DONE), the default WIDTH constant and the counter-width function (clog2).
REQ-028 The bit-level full subtractor SHALL be one gate-level sub-module, fs_str (ports a, b, bin, d, bout), instantiated once.

Verification
REQ-029 WIDTH=8: a=0x35, b=0x12 -> diff=0x23, borrow=0, out_valid 9 edges after accept.
REQ-030 a=0x10, b=0x20 -> diff=0xF0, borrow=1; diff=0x00, borrow=1 with SERIAL_SUB_SAT_EN.
REQ-031 a=0xFF, b=0x01 -> diff=0xFE, borrow=0; a=0x00, b=0x00 -> diff=0x00, borrow=0.
REQ-032 out_ready held low 5 cycles in DONE -> diff and borrow stable, out_valid=1 throughout; in_valid pulses ignored.
REQ-033 rst_n=0 at bit-cycle 4 of RUN -> next cycle IDLE, out_valid=0, in_ready=1; the next op a=0x07, b=0x03 -> diff=0x04.
REQ-034 Back-to-back ops with in_valid and out_ready tied high -> accepts spaced exactly 10 cycles; random 1000 pairs checked against a-b.
